data_memory_sync: RTL and testbench
===================================

DATA_MEMORY_SYNC -- requirements
Module: data_memory_sync

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter ADDR_W, default 8, address width in bits.
REQ-003 Parameter DEPTH, default 32, number of words; the block SHALL require DEPTH <= 2**ADDR_W.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  1  access request, sampled on rising clk.
REQ-007 write  input  1  qualifies req: 1 = write, 0 = read.
REQ-008 address  input  ADDR_W  word address of the access.
REQ-009 writeData  input  DATA_W  write data.
REQ-010 ready  output  1  high when the block accepts requests.
REQ-011 readData  output  DATA_W  registered read data.
REQ-012 rvalid  output  1  one-cycle pulse marking readData valid.
REQ-013 err  output  1  one-cycle pulse marking a rejected out-of-range access.

Function
REQ-014 The block SHALL implement a two-state FSM (INIT, RUN) plus an init counter of width ceil(log2(DEPTH+1)).
REQ-015 INIT: one word per cycle, memory[i] <= i mod 16; for 16 < i < DEPTH, the word SHALL be the two's-complement negation of (i mod 16), truncated to DATA_W bits.
REQ-016 INIT SHALL write indices 0..DEPTH-1 in ascending order; the FSM SHALL enter RUN on the edge after index DEPTH-1 is written, so ready rises exactly DEPTH cycles after reset deasserts.
REQ-017 While in INIT, ready SHALL be 0 and req SHALL be ignored: no memory change, no rvalid, no err.
REQ-018 RUN: ready SHALL be 1; a request is accepted on any rising edge with req=1.
REQ-019 An accepted write with address < DEPTH SHALL update memory[address] with writeData on that edge; rvalid SHALL stay 0.
REQ-020 An accepted read with address < DEPTH SHALL drive readData = memory[address] and rvalid = 1 on the next cycle (latency 1).
REQ-021 readData SHALL hold its last value while rvalid=0.
REQ-022 Back-to-back reads on consecutive cycles SHALL be supported at full throughput, one rvalid per read.
REQ-023 A read to the address written on the previous edge SHALL return the newly written data.
REQ-024 An access with address >= DEPTH SHALL NOT modify memory; it SHALL pulse err for one cycle; for a read, readData SHALL be 0 and rvalid SHALL stay 0.
REQ-025 Address arithmetic SHALL be unsigned, with no wrap-around modulo DEPTH.

Reset
REQ-026 Reset assertion SHALL force, without waiting for clk: FSM=INIT, init counter=0, ready=0, rvalid=0, err=0, readData=0.
REQ-027 Reset asserted mid-INIT or mid-RUN SHALL abort any in-flight access and restart INIT from index 0 after deassertion.
REQ-028 Memory contents SHALL be defined only by the INIT sequence.
REQ-029 Memory contents SHALL NOT be cleared asynchronously.

Verification (DATA_W=8, DEPTH=32)
REQ-030 Pulse reset, then count clocks -> ready=0 for exactly 32 cycles, then ready=1; no rvalid or err during INIT even with req=1, write=1.
REQ-031 Read addresses 3, 16, 17, 31 after INIT -> readData 0x03, 0x00, 0xFF, 0xF1, each with rvalid one cycle after req.
REQ-032 Write 0xA5 to address 5, then read 5 on the next cycle -> readData=0xA5, rvalid=1; read 6 -> 0x06.
REQ-033 Read address 40 and write 0x55 to address 32 -> err pulses one cycle each, rvalid stays 0; a later read of 0 returns 0x00.
REQ-034 Assert reset at INIT index 10, release, after RUN read 5 -> ready delayed a full 32 cycles from release, readData=0x05, any earlier write overwritten.
REQ-035 Issue reads of 1, 2, 3 on consecutive cycles -> rvalid high three consecutive cycles with readData 0x01, 0x02, 0x03.

Source files
------------

// File: rtl/data_memory_sync_if.sv
// Request/response bus of the synchronous data memory: the requester drives
// the master side, data_memory_sync implements the slave side.
interface data_memory_sync_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              req;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writeData;
    logic              ready;
    logic [DATA_W-1:0] readData;
    logic              rvalid;
    logic              err;

    modport master (
        output req, write, address, writeData,
        input  ready, readData, rvalid, err
    );

    modport slave (
        input  req, write, address, writeData,
        output ready, readData, rvalid, err
    );
endinterface

// File: rtl/data_memory_sync.sv
// Single-port synchronous data memory that self-initialises one word per cycle
// after reset, then serves reads (latency 1) and writes with range checking.
module data_memory_sync #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    data_memory_sync_if.slave bus
);
    localparam int                CNT_W     = $clog2(DEPTH + 1);
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_read_data;
    logic              r_rvalid;
    logic              r_err;

    logic              w_accept;
    logic              w_in_range;
    logic              w_mem_we;
    logic [IDX_W-1:0]  w_mem_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [DATA_W-1:0] w_mem_data;
    logic [DATA_W-1:0] w_init_data;
    int                w_init_mod;

    // Zero-extend the address so the compare stays unsigned and never wraps.
    assign w_in_range = ({1'b0, bus.address} < DEPTH_EXT);
    assign w_accept   = (r_state == S_RUN) && bus.req;
    assign w_rd_idx   = bus.address[IDX_W-1:0];

    // Init pattern: i mod 16, negated above index 16.
    always_comb begin
        w_init_mod  = int'(r_cnt) % 16;
        w_init_data = (int'(r_cnt) > 16) ? DATA_W'(-w_init_mod) : DATA_W'(w_init_mod);
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_mem_we     = 1'b0;
        w_mem_idx    = w_rd_idx;
        w_mem_data   = bus.writeData;
        case (r_state)
            S_INIT: begin
                w_mem_we   = 1'b1;
                w_mem_idx  = r_cnt[IDX_W-1:0];
                w_mem_data = w_init_data;
                if (r_cnt == LAST_IDX) begin
                    w_state_next = S_RUN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_RUN: w_mem_we = w_accept && bus.write && w_in_range;
            default: w_state_next = S_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // NOTE: the array has no reset; its contents come only from the init sweep.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_read_data <= '0;
            r_rvalid    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_rvalid <= w_accept && !bus.write && w_in_range;
            r_err    <= w_accept && !w_in_range;
            if (w_accept && !bus.write) begin
                r_read_data <= w_in_range ? r_mem[w_rd_idx] : '0;
            end
        end
    end

    assign bus.ready    = (r_state == S_RUN);
    assign bus.readData = r_read_data;
    assign bus.rvalid   = r_rvalid;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_data_memory_sync.sv
// Scoreboard bench for data_memory_sync: the driver predicts responses from an
// array model and queues them; a negedge monitor compares what the DUT presents.
module tb_data_memory_sync;
    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 32;

    typedef struct {
        int          due;
        bit          is_err;
        bit          is_read;
        logic [7:0]  data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   run_mode = 1'b0;
    logic [7:0] model [DEPTH];
    logic [7:0] last_rd = 8'h00;
    exp_t exp_q [$];

    data_memory_sync_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    data_memory_sync #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference contents after the init sweep.
    task automatic model_init();
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 16) model[i] = 8'(-(i % 16));
            else        model[i] = 8'(i % 16);
        end
    endtask

    task automatic drive_point();
        @(negedge clk);
        #1;
    endtask

    task automatic step(input bit rq, input bit wr, input logic [7:0] a, input logic [7:0] d);
        drive_point();
        bus.req       = rq;
        bus.write     = wr;
        bus.address   = a;
        bus.writeData = d;
        if (rq && run_mode) begin
            if (int'(a) >= DEPTH) exp_q.push_back('{cyc + 1, 1'b1, !wr, 8'h00});
            else if (wr)          model[a] = d;
            else                  exp_q.push_back('{cyc + 1, 1'b0, 1'b1, model[a]});
        end
    endtask

    // Called at a drive point; outputs must clear before any clock edge.
    task automatic assert_reset();
        reset    = 1'b1;
        run_mode = 1'b0;
        exp_q.delete();
        last_rd  = 8'h00;
        #1;
        check("rst_ready",  32'(bus.ready),    32'd0);
        check("rst_rvalid", 32'(bus.rvalid),   32'd0);
        check("rst_err",    32'(bus.err),      32'd0);
        check("rst_rdata",  32'(bus.readData), 32'd0);
    endtask

    // Called at the drive point where reset is released; hammers writes during INIT.
    task automatic init_wait();
        reset = 1'b0;
        model_init();
        for (int k = 0; k < DEPTH; k++) begin
            check("init_ready_low", 32'(bus.ready), 32'd0);
            bus.req       = 1'b1;
            bus.write     = 1'b1;
            bus.address   = 8'($urandom_range(0, DEPTH - 1));
            bus.writeData = 8'($urandom);
            drive_point();
        end
        check("init_ready_high", 32'(bus.ready), 32'd1);
        bus.req  = 1'b0;
        run_mode = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                if (e.is_err) begin
                    check("err_pulse",  32'(bus.err),    32'd1);
                    check("err_rvalid", 32'(bus.rvalid), 32'd0);
                    if (e.is_read) last_rd = 8'h00;
                    check("err_rdata", 32'(bus.readData), 32'(last_rd));
                end else begin
                    check("rd_rvalid", 32'(bus.rvalid),   32'd1);
                    check("rd_err",    32'(bus.err),      32'd0);
                    check("rd_data",   32'(bus.readData), 32'(e.data));
                    last_rd = e.data;
                end
            end else begin
                check("idle_rvalid", 32'(bus.rvalid),   32'd0);
                check("idle_err",    32'(bus.err),      32'd0);
                check("hold_rdata",  32'(bus.readData), 32'(last_rd));
            end
        end
    end

    initial begin : driver
        bus.req       = 1'b0;
        bus.write     = 1'b0;
        bus.address   = '0;
        bus.writeData = '0;
        #1;
        check("por_ready",  32'(bus.ready),    32'd0);
        check("por_rvalid", 32'(bus.rvalid),   32'd0);
        check("por_rdata",  32'(bus.readData), 32'd0);
        repeat (3) drive_point();
        init_wait();

        // Init pattern spot checks, back to back.
        step(1, 0, 8'd3,  8'h00);
        step(1, 0, 8'd16, 8'h00);
        step(1, 0, 8'd17, 8'h00);
        step(1, 0, 8'd31, 8'h00);
        step(0, 0, 8'd0,  8'h00);
        // Write then read-after-write.
        step(1, 1, 8'd5,  8'hA5);
        step(1, 0, 8'd5,  8'h00);
        step(1, 0, 8'd6,  8'h00);
        step(0, 0, 8'd0,  8'h00);
        // Out-of-range read and write.
        step(1, 0, 8'd40, 8'h00);
        step(0, 0, 8'd0,  8'h00);
        step(1, 1, 8'd32, 8'h55);
        step(1, 0, 8'd0,  8'h00);
        step(1, 0, 8'd31, 8'h00);
        step(1, 1, 8'd255, 8'h12);
        // Full-throughput reads.
        step(1, 0, 8'd1,  8'h00);
        step(1, 0, 8'd2,  8'h00);
        step(1, 0, 8'd3,  8'h00);
        step(0, 0, 8'd0,  8'h00);

        // Reset mid-RUN with a read presented before its edge: it must be dropped.
        step(1, 1, 8'd5, 8'h77);
        step(1, 0, 8'd5, 8'h00);
        step(0, 0, 8'd0, 8'h00);
        drive_point();
        bus.req     = 1'b1;
        bus.write   = 1'b0;
        bus.address = 8'd7;
        assert_reset();
        repeat (2) drive_point();
        init_wait();
        step(1, 0, 8'd5, 8'h00);

        // Randomized traffic, including out-of-range addresses.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 47)), 8'($urandom));
        end

        // Reset at init index 10, then a full init from release.
        step(1, 1, 8'd5, 8'h3C);
        step(0, 0, 8'd0, 8'h00);
        drive_point();
        assert_reset();
        repeat (2) drive_point();
        reset = 1'b0;
        bus.req = 1'b1;
        bus.write = 1'b1;
        bus.address = 8'd5;
        bus.writeData = 8'hEE;
        repeat (10) drive_point();
        assert_reset();
        drive_point();
        init_wait();
        step(1, 0, 8'd5,  8'h00);
        step(1, 0, 8'd20, 8'h00);

        repeat (3) step(0, 0, 8'd0, 8'h00);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
